// File: rtl/inst_buffer_pkg.sv
// Shared pipeline types for the fetch/decode boundary: the buffered entry layout and default depth.
package pipeline_types;

  localparam int IB_DEPTH = 16;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        is_branch;
    logic        pre_taken;
  } ib_entry_t;

endpackage

// File: rtl/inst_buffer_if.sv
// Fetch-side push bus and decode-side pop bus of the instruction buffer.
// master = the buffer itself, slave = the surrounding front end / decode.
interface inst_buffer_if import pipeline_types::*; #(
  parameter int DEPTH = IB_DEPTH
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          flush;
  logic          fetch_inst_1_en;
  logic          fetch_inst_2_en;
  logic [31:0]   inst_1_i;
  logic [31:0]   inst_2_i;
  logic [31:0]   pc_1_i;
  logic [31:0]   pc_2_i;
  logic          is_branch_1_i;
  logic          is_branch_2_i;
  logic          pre_taken_i;
  logic          decode_ready_1;
  logic          decode_ready_2;
  logic          full_o;
  logic          valid_1_o;
  logic          valid_2_o;
  logic [31:0]   inst_1_o;
  logic [31:0]   inst_2_o;
  logic [31:0]   pc_1_o;
  logic [31:0]   pc_2_o;
  logic          is_branch_1_o;
  logic          is_branch_2_o;
  logic          pre_taken_1_o;
  logic          pre_taken_2_o;
  logic [CW-1:0] count_o;
`ifdef IB_FULL_CNT_EN
  logic [31:0]   full_cycles_o;
`endif

  modport master (
    input  flush, fetch_inst_1_en, fetch_inst_2_en, inst_1_i, inst_2_i, pc_1_i, pc_2_i,
    input  is_branch_1_i, is_branch_2_i, pre_taken_i, decode_ready_1, decode_ready_2,
    output full_o, valid_1_o, valid_2_o, inst_1_o, inst_2_o, pc_1_o, pc_2_o,
    output is_branch_1_o, is_branch_2_o, pre_taken_1_o, pre_taken_2_o, count_o
`ifdef IB_FULL_CNT_EN
    , output full_cycles_o
`endif
  );

  modport slave (
    output flush, fetch_inst_1_en, fetch_inst_2_en, inst_1_i, inst_2_i, pc_1_i, pc_2_i,
    output is_branch_1_i, is_branch_2_i, pre_taken_i, decode_ready_1, decode_ready_2,
    input  full_o, valid_1_o, valid_2_o, inst_1_o, inst_2_o, pc_1_o, pc_2_o,
    input  is_branch_1_o, is_branch_2_o, pre_taken_1_o, pre_taken_2_o, count_o
`ifdef IB_FULL_CNT_EN
    , input full_cycles_o
`endif
  );

endinterface

// File: rtl/inst_buffer_ptr.sv
// Head/tail/occupancy tracker for the instruction buffer; flush wins over same-cycle pushes/pops.
// Pointers wrap naturally at DEPTH (power of two); count is one bit wider so it can reach DEPTH.
module ib_ptr import pipeline_types::*; #(
  parameter int DEPTH = IB_DEPTH,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_flush,
  input  logic [1:0]    i_push_cnt,
  input  logic [1:0]    i_pop_cnt,
  output logic [AW-1:0] o_head,
  output logic [AW-1:0] o_tail,
  output logic [CW-1:0] o_count
);

  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + AW'(i_pop_cnt);
      r_tail  <= r_tail + AW'(i_push_cnt);
      r_count <= r_count + CW'(i_push_cnt) - CW'(i_pop_cnt);
    end
  end

  assign o_head  = r_head;
  assign o_tail  = r_tail;
  assign o_count = r_count;

endmodule

// File: rtl/inst_buffer.sv
// Two-in/two-out in-order instruction FIFO between fetch and decode; 1-cycle write-to-read, no bypass.
// full_o holds the front end when fewer than 2 slots are free; optional blocked-fetch counter via IB_FULL_CNT_EN.
module inst_buffer import pipeline_types::*; #(
  parameter int DEPTH = IB_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  inst_buffer_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  ib_entry_t     r_mem [DEPTH];
  logic [AW-1:0] w_head;
  logic [AW-1:0] w_tail;
  logic [CW-1:0] w_count;
  logic          w_full;
  logic          w_push1;
  logic          w_push2;
  logic          w_valid1;
  logic          w_valid2;
  logic          w_pop1;
  logic          w_pop2;
  logic [1:0]    w_push_cnt;
  logic [1:0]    w_pop_cnt;
  ib_entry_t     w_in1;
  ib_entry_t     w_in2;
  ib_entry_t     w_out1;
  ib_entry_t     w_out2;

  // full is taken from the registered count, so same-cycle pops never admit extra writes
  assign w_full     = (w_count >= CW'(DEPTH - 1));
  assign w_push1    = bus.fetch_inst_1_en & ~w_full;
  assign w_push2    = bus.fetch_inst_2_en & ~w_full;
  assign w_push_cnt = {1'b0, w_push1} + {1'b0, w_push2};

  assign w_valid1  = (w_count >= CW'(1));
  assign w_valid2  = (w_count >= CW'(2));
  assign w_pop1    = w_valid1 & bus.decode_ready_1;
  assign w_pop2    = w_pop1 & w_valid2 & bus.decode_ready_2;
  assign w_pop_cnt = {1'b0, w_pop1} + {1'b0, w_pop2};

  assign w_in1 = '{pc: bus.pc_1_i, inst: bus.inst_1_i, is_branch: bus.is_branch_1_i,
                   pre_taken: bus.is_branch_1_i & bus.pre_taken_i};
  assign w_in2 = '{pc: bus.pc_2_i, inst: bus.inst_2_i, is_branch: bus.is_branch_2_i,
                   pre_taken: bus.is_branch_2_i & bus.pre_taken_i};

  ib_ptr #(.DEPTH(DEPTH)) u_ptr (
    .clk        (clk),
    .rst        (rst),
    .i_flush    (bus.flush),
    .i_push_cnt (w_push_cnt),
    .i_pop_cnt  (w_pop_cnt),
    .o_head     (w_head),
    .o_tail     (w_tail),
    .o_count    (w_count)
  );

  // Storage is deliberately left unreset; the valids mask stale contents.
  always_ff @(posedge clk) begin
    if (!bus.flush) begin
      if (w_push1) r_mem[w_tail] <= w_in1;
      if (w_push2) r_mem[w_push1 ? w_tail + AW'(1) : w_tail] <= w_in2;
    end
  end

  assign w_out1 = w_valid1 ? r_mem[w_head] : '0;
  assign w_out2 = w_valid2 ? r_mem[w_head + AW'(1)] : '0;

  assign bus.full_o        = w_full;
  assign bus.valid_1_o     = w_valid1;
  assign bus.valid_2_o     = w_valid2;
  assign bus.inst_1_o      = w_out1.inst;
  assign bus.inst_2_o      = w_out2.inst;
  assign bus.pc_1_o        = w_out1.pc;
  assign bus.pc_2_o        = w_out2.pc;
  assign bus.is_branch_1_o = w_out1.is_branch;
  assign bus.is_branch_2_o = w_out2.is_branch;
  assign bus.pre_taken_1_o = w_out1.pre_taken;
  assign bus.pre_taken_2_o = w_out2.pre_taken;
  assign bus.count_o       = w_count;

`ifdef IB_FULL_CNT_EN
  logic [31:0] r_full_cycles;

  // counts blocked fetch attempts; survives flush, saturates at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full_cycles <= '0;
    end else if (w_full && (bus.fetch_inst_1_en || bus.fetch_inst_2_en) &&
                 (r_full_cycles != 32'hFFFF_FFFF)) begin
      r_full_cycles <= r_full_cycles + 32'd1;
    end
  end

  assign bus.full_cycles_o = r_full_cycles;
`endif

endmodule
